// File: rtl/vga_chk_pkg.sv
// Shared constants for the VGA frame checker: FSM states, CRC-16-CCITT
// parameters, counter widths and the single-bit CRC step.
package vga_chk_pkg;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  // One MSB-first CRC-16 step, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ d) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Serial CRC-16-CCITT shifter, one bit per enabled clock; init has priority.
module crc16_serial
  import vga_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc16_step(crc, din);
  end

endmodule

// File: rtl/vga_frame_checker.sv
// VGA frame checker: measures line/frame timing, signs each frame's active
// pixels with CRC-16 and locks on consecutive identical frames.
// Optional: VGA_FRAME_CHECKER_ERRCNT_EN adds the err_cnt output.
module vga_frame_checker
  import vga_chk_pkg::*;
#(
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_ACTIVE    = 480,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               pix,
  output logic               frame_done,
  output logic               locked,
  output logic [15:0]        crc,
  output logic [H_CNT_W-1:0] h_total,
  output logic [V_CNT_W-1:0] v_total
`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  logic               hs_r, vs_r, pix_r, hs_q, vs_q;
  logic               hs_edge, vs_edge;
  logic [H_CNT_W-1:0] h_cnt, h_cnt_p1, h_line;
  logic [V_CNT_W-1:0] v_cnt, v_cnt_p1;
  logic               v_sat, h_act, v_act, frame_match, reach;
  logic [15:0]        crc_acc;
  logic [1:0]         state, state_nxt;
  logic [2:0]         match_cnt, match_nxt, match_inc;
  logic               latch;

  // Input registers plus one-cycle-delayed syncs for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r  <= ~SYNC_ACTIVE;
      vs_r  <= ~SYNC_ACTIVE;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
      pix_r <= 1'b0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_q  <= hs_r;
      vs_q  <= vs_r;
      pix_r <= pix;
    end
  end

  assign hs_edge  = (hs_r == SYNC_ACTIVE) && (hs_q != SYNC_ACTIVE);
  assign vs_edge  = (vs_r == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);
  assign h_cnt_p1 = (&h_cnt) ? h_cnt : h_cnt + H_CNT_W'(1);
  assign v_sat    = &v_cnt;
  assign v_cnt_p1 = v_sat ? v_cnt : v_cnt + V_CNT_W'(1);
  assign h_act    = (32'(h_cnt) >= H_START) && (32'(h_cnt) < H_START + H_ACTIVE);
  assign v_act    = (32'(v_cnt) >= V_START) && (32'(v_cnt) < V_START + V_ACTIVE);

  // Saturating line/frame position counters; a vsync edge overrides hsync for v_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt  <= '0;
      h_line <= '0;
      v_cnt  <= '0;
    end else begin
      if (hs_edge) begin
        h_cnt  <= '0;
        h_line <= h_cnt_p1;
      end else begin
        h_cnt  <= h_cnt_p1;
      end
      if (vs_edge)      v_cnt <= '0;
      else if (hs_edge) v_cnt <= v_cnt_p1;
    end
  end

  crc16_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (vs_edge),
    .en    (h_act && v_act),
    .din   (pix_r),
    .crc   (crc_acc)
  );

  assign frame_match = (crc_acc == crc) && (h_line == h_total) && (v_cnt_p1 == v_total);
  assign match_inc   = match_cnt + 3'd1;
  assign reach       = 32'(match_inc) >= LOCK_FRAMES;

  // FSM state and match counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  // Next state: frame-boundary handling and vsync-loss fallback.
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    latch     = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_edge) state_nxt = FIRST;
      end
      FIRST: begin
        if (vs_edge) begin
          latch     = 1'b1;
          match_nxt = '0;
          state_nxt = CHECK;
        end else if (v_sat) begin
          state_nxt = SEARCH;
          match_nxt = '0;
        end
      end
      CHECK: begin
        if (vs_edge) begin
          latch = 1'b1;
          if (frame_match) begin
            match_nxt = match_inc;
            if (reach) state_nxt = LOCKED;
          end else begin
            match_nxt = '0;
          end
        end else if (v_sat) begin
          state_nxt = SEARCH;
          match_nxt = '0;
        end
      end
      LOCKED: begin
        if (vs_edge) begin
          latch = 1'b1;
          if (!frame_match) begin
            state_nxt = CHECK;
            match_nxt = '0;
          end
        end else if (v_sat) begin
          state_nxt = SEARCH;
          match_nxt = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        match_nxt = '0;
      end
    endcase
  end

  // Registered outputs; frame stats only update on a latching boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      locked     <= 1'b0;
      crc        <= '0;
      h_total    <= '0;
      v_total    <= '0;
    end else begin
      frame_done <= latch;
      locked     <= (state_nxt == LOCKED);
      if (latch) begin
        crc     <= crc_acc;
        h_total <= h_line;
        v_total <= v_cnt_p1;
      end
    end
  end

`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
  logic err_inc;
  assign err_inc = (state == LOCKED) && (vs_edge ? !frame_match : v_sat);

  // Saturating count of lock losses (mismatch or vsync loss while locked).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_cnt <= '0;
    else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  // No error counter in this build.
`endif

endmodule

// File: tb/tb_vga_frame_checker.sv
// Scoreboard bench for vga_frame_checker on a scaled-down raster (16x9) so
// the run stays short; a second instance sees inverted syncs with SYNC_ACTIVE=1.
module tb_vga_frame_checker;

  localparam int HS    = 3;
  localparam int HA    = 8;
  localparam int VS    = 2;
  localparam int VA    = 5;
  localparam int LOCKN = 2;
  localparam int LINE  = 16;
  localparam int NLINES = 9;

  logic clk = 1'b0;
  logic rst_n, hs, vs, pix;
  logic fd0, lk0, fd1, lk1;
  logic [15:0] crc0, crc1;
  logic [10:0] ht0, ht1;
  logic [9:0]  vt0, vt1;
`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
  logic [7:0] err0, err1;
`endif

  always #5 clk = ~clk;

  vga_frame_checker #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA),
                      .SYNC_ACTIVE(1'b0), .LOCK_FRAMES(LOCKN)) dut0 (
    .clk(clk), .rst_n(rst_n), .hsync(hs), .vsync(vs), .pix(pix),
    .frame_done(fd0), .locked(lk0), .crc(crc0), .h_total(ht0), .v_total(vt0)
`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
    , .err_cnt(err0)
`endif
  );

  vga_frame_checker #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA),
                      .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(LOCKN)) dut1 (
    .clk(clk), .rst_n(rst_n), .hsync(~hs), .vsync(~vs), .pix(pix),
    .frame_done(fd1), .locked(lk1), .crc(crc1), .h_total(ht1), .v_total(vt1)
`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
    , .err_cnt(err1)
`endif
  );

  typedef struct {
    logic [15:0] crc;
    int          ht;
    int          vt;
    logic        lk;
    int          err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: frame-level lock tracking.
  int          mst;     // 0 searching, 1 first frame seen, 2 comparing, 3 locked
  int          mmatch, merr, pht, pvt, cur_lines, mode;
  logic [15:0] pcrc, cur_crc;
  logic        img [NLINES][LINE];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    c  = c << 1;
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  // The checker's h_cnt trails the pin by one clock (input register + edge detect),
  // so active pin columns are HS+1..HS+HA; line v counts hsyncs since vsync.
  function automatic bit in_win(input int x, input int v);
    return (x >= HS + 1) && (x <= HS + HA) && (v >= VS) && (v < VS + VA);
  endfunction

  task automatic model_reset();
    mst = 0; mmatch = 0; merr = 0; pcrc = '0; pht = 0; pvt = 0;
    cur_crc = 16'hFFFF; cur_lines = 0;
    sbq.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    bit   same;
    same = (cur_crc == pcrc) && (LINE == pht) && (cur_lines == pvt);
    if (mst != 0) begin
      if (mst == 1) begin
        mmatch = 0; mst = 2;
      end else if (mst == 2) begin
        if (same) begin
          mmatch++;
          if (mmatch >= LOCKN) mst = 3;
        end else mmatch = 0;
      end else if (!same) begin
        mst = 2; mmatch = 0;
        if (merr < 255) merr++;
      end
      pcrc = cur_crc; pht = LINE; pvt = cur_lines;
      e.crc = pcrc; e.ht = pht; e.vt = pvt; e.lk = (mst == 3); e.err = merr; e.cyc = cyc + 2;
      sbq.push_back(e);
    end else begin
      mst = 1;
    end
    cur_crc = 16'hFFFF; cur_lines = 0;
  endtask

  task automatic model_loss();
    if (mst != 0) begin
      if (mst == 3 && merr < 255) merr++;
      mst = 0; mmatch = 0;
    end
  endtask

  task automatic set_image(input int m);
    mode = m;
    for (int y = 0; y < NLINES; y++)
      for (int x = 0; x < LINE; x++)
        img[y][x] = (m == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (m == 1) img[VS][HS + 1] = 1'b1;
  endtask

  // Drive one frame (vsync with hsync at its first clock); abort_at >= 0 stops early.
  task automatic run_frame(input int lines, input bit with_vs, input bit flip, input int abort_at);
    int   n;
    logic p;
    bit   win;
    n = 0;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < LINE; x++) begin
        @(posedge clk); #1;
        if (abort_at >= 0 && n == abort_at) return;
        n++;
        if (with_vs && x == 0 && y == 0) model_edge();
        if (x == 0) begin
          cur_lines++;
          if (cur_lines == 1024) model_loss();
        end
        win = in_win(x, cur_lines - 1);
        p = (y < NLINES) ? img[y][x] : 1'b0;
        if (!win && mode == 2) p = 1'($urandom_range(0, 1));
        if (flip && win && x == HS + 3 && cur_lines - 1 == VS + 1) p = ~p;
        hs  = !(x < 2);
        vs  = !(with_vs && y < 2);
        pix = p;
        if (win) cur_crc = ref_crc(cur_crc, p);
      end
    end
  endtask

  task automatic check_zero_outputs();
    chk("rst_frame_done0", 32'(fd0), 0);  chk("rst_frame_done1", 32'(fd1), 0);
    chk("rst_locked0", 32'(lk0), 0);      chk("rst_locked1", 32'(lk1), 0);
    chk("rst_crc0", 32'(crc0), 0);        chk("rst_crc1", 32'(crc1), 0);
    chk("rst_h_total0", 32'(ht0), 0);     chk("rst_h_total1", 32'(ht1), 0);
    chk("rst_v_total0", 32'(vt0), 0);     chk("rst_v_total1", 32'(vt1), 0);
`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
    chk("rst_err_cnt0", 32'(err0), 0);    chk("rst_err_cnt1", 32'(err1), 0);
`endif
  endtask

  task automatic do_reset();
    hs = 1'b1; vs = 1'b1; pix = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every frame_done pulse consumes one expected frame record.
  always @(negedge clk) begin
    if (rst_n && (fd0 || fd1)) begin
      if (sbq.size() == 0) begin
        chk("spurious_frame_done0", 32'(fd0), 0);
        chk("spurious_frame_done1", 32'(fd1), 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("frame_done0", 32'(fd0), 1);   chk("frame_done1", 32'(fd1), 1);
        chk("frame_done_cycle", 32'(cyc), 32'(e.cyc));
        chk("crc0", 32'(crc0), 32'(e.crc)); chk("crc1", 32'(crc1), 32'(e.crc));
        chk("h_total0", 32'(ht0), 32'(e.ht)); chk("h_total1", 32'(ht1), 32'(e.ht));
        chk("v_total0", 32'(vt0), 32'(e.vt)); chk("v_total1", 32'(vt1), 32'(e.vt));
        chk("locked0", 32'(lk0), 32'(e.lk)); chk("locked1", 32'(lk1), 32'(e.lk));
`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
        chk("err_cnt0", 32'(err0), 32'(e.err)); chk("err_cnt1", 32'(err1), 32'(e.err));
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; hs = 1'b1; vs = 1'b1; pix = 1'b0; mode = 0;
    model_reset();
    do_reset();

    set_image(0);
    repeat (6) run_frame(NLINES, 1'b1, 1'b0, -1);

    set_image(1);
    repeat (5) run_frame(NLINES, 1'b1, 1'b0, -1);

    set_image(2);
    repeat (4) run_frame(NLINES, 1'b1, 1'b0, -1);
    run_frame(NLINES, 1'b1, 1'b1, -1);
    repeat (5) run_frame(NLINES, 1'b1, 1'b0, -1);

    // vsync lost while hsync continues
    run_frame(1100, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("loss_locked0", 32'(lk0), 0);   chk("loss_locked1", 32'(lk1), 0);
    chk("loss_crc_hold", 32'(crc0), 32'(pcrc));
    chk("loss_h_total_hold", 32'(ht0), 32'(pht));
    chk("loss_v_total_hold", 32'(vt0), 32'(pvt));
    chk("loss_crc_hold1", 32'(crc1), 32'(pcrc));
`ifdef VGA_FRAME_CHECKER_ERRCNT_EN
    chk("loss_err_cnt0", 32'(err0), 32'(merr));
`endif

    repeat (5) run_frame(NLINES, 1'b1, 1'b0, -1);

    // reset mid-frame, then re-acquire lock
    run_frame(NLINES, 1'b1, 1'b0, 60);
    do_reset();
    repeat (6) run_frame(NLINES, 1'b1, 1'b0, -1);
    run_frame(1, 1'b1, 1'b0, -1);
    hs = 1'b1; vs = 1'b1; pix = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
